decode_stage: RTL and testbench

- Registered RISC-V instruction-decode pipeline stage with a valid/ready handshake on both sides. It sits between fetch and issue/execute.
- It extracts register fields, selects and sign-extends the single immediate for the instruction's format, classifies the format, flags illegal encodings and computes rd write-enable.
- It is parametrised for RV32I/RV64I.
- A 2-entry skid buffer gives full throughput with a registered in_ready.

---
 rtl/decode_pkg.sv | 36 +++
 rtl/decode_comb.sv | 142 ++++++++++++++
 rtl/decode_stage.sv | 136 +++++++++++++
 tb/tb_decode_stage.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// ============================================================================
// Module      : decode_pkg
// Description : Opcode, format and funct7 constants shared by the decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package decode_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

`default_nettype wire

// File: rtl/decode_comb.sv
// ============================================================================
// Module      : decode_comb
// Description : Combinational RISC-V field, immediate, format, legality and
//               rd write-enable decode for RV32I / RV64I.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_comb
    import decode_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit RV64_OPS = (XLEN == 64)
) (
    input  logic [31:0]     i_instr,
    output logic [6:0]      o_opcode,
    output logic [2:0]      o_funct3,
    output logic [6:0]      o_funct7,
    output logic [4:0]      o_rd_addr,
    output logic [4:0]      o_rs1_addr,
    output logic [4:0]      o_rs2_addr,
    output logic [XLEN-1:0] o_imm,
    output logic [2:0]      o_fmt,
    output logic            o_rd_we,
    output logic            o_illegal
);

    // Bit 25 belongs to shamt on RV64, so it is excluded from the shift checks.
    localparam logic [6:0] c_sh_mask = (XLEN == 64) ? 7'b1111110 : 7'b1111111;

    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_imm_j;
    logic [6:0]      w_sh_hi;
    logic [2:0]      w_fmt;
    logic            w_we;
    logic            w_ill;

    assign o_opcode   = i_instr[6:0];
    assign o_funct3   = i_instr[14:12];
    assign o_funct7   = i_instr[31:25];
    assign o_rd_addr  = i_instr[11:7];
    assign o_rs1_addr = i_instr[19:15];
    assign o_rs2_addr = i_instr[24:20];

    assign w_imm_i = XLEN'(signed'(i_instr[31:20]));
    assign w_imm_s = XLEN'(signed'({i_instr[31:25], i_instr[11:7]}));
    assign w_imm_b = XLEN'(signed'({i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0}));
    assign w_imm_u = XLEN'(signed'({i_instr[31:12], 12'b0}));
    assign w_imm_j = XLEN'(signed'({i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0}));
    assign w_sh_hi = i_instr[31:25] & c_sh_mask;

    always_comb begin
        w_fmt = FMT_I;
        w_we  = 1'b0;
        w_ill = 1'b0;
        case (o_opcode)
            OPC_LUI, OPC_AUIPC: begin
                w_fmt = FMT_U;
                w_we  = 1'b1;
            end
            OPC_JAL: begin
                w_fmt = FMT_J;
                w_we  = 1'b1;
            end
            OPC_JALR: begin
                w_we  = 1'b1;
                w_ill = (o_funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                w_fmt = FMT_B;
                w_ill = (o_funct3[2:1] == 2'b01);
            end
            OPC_LOAD: begin
                w_we = 1'b1;
                case (o_funct3)
                    3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_ill = 1'b0;
                    3'b011, 3'b110:                         w_ill = !RV64_OPS;
                    default:                                w_ill = 1'b1;
                endcase
            end
            OPC_STORE: begin
                w_fmt = FMT_S;
                w_ill = o_funct3[2] || ((o_funct3 == 3'b011) && !RV64_OPS);
            end
            OPC_OP_IMM: begin
                w_we = 1'b1;
                if (o_funct3 == 3'b001) begin
                    w_ill = (w_sh_hi != F7_BASE);
                end else if (o_funct3 == 3'b101) begin
                    w_ill = (w_sh_hi != F7_BASE) && (w_sh_hi != F7_ALT);
                end
            end
            OPC_OP_IMM32: begin
                w_we  = 1'b1;
                w_ill = !RV64_OPS;
            end
            OPC_OP: begin
                w_fmt = FMT_R;
                w_we  = 1'b1;
                w_ill = !((o_funct7 == F7_BASE) ||
                          ((o_funct7 == F7_ALT) && ((o_funct3 == 3'b000) || (o_funct3 == 3'b101))));
            end
            OPC_OP32: begin
                w_fmt = FMT_R;
                w_we  = 1'b1;
                w_ill = !RV64_OPS;
            end
            OPC_MISC_MEM: w_fmt = FMT_I;
            OPC_SYSTEM:   w_we  = (o_funct3 != 3'b000);
            default:      w_ill = 1'b1;
        endcase

        if (i_instr[1:0] != 2'b11) begin
            w_ill = 1'b1;
        end
        // Illegal encodings are presented as harmless I-type with no writeback.
        if (w_ill) begin
            w_fmt = FMT_I;
            w_we  = 1'b0;
        end
    end

    always_comb begin
        o_fmt     = w_fmt;
        o_illegal = w_ill;
        o_rd_we   = w_we && (o_rd_addr != 5'd0);
        case (w_fmt)
            FMT_R:   o_imm = '0;
            FMT_S:   o_imm = w_imm_s;
            FMT_B:   o_imm = w_imm_b;
            FMT_U:   o_imm = w_imm_u;
            FMT_J:   o_imm = w_imm_j;
            default: o_imm = w_imm_i;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
// ============================================================================
// Module      : decode_stage
// Description : Registered RISC-V decode stage with valid/ready handshake and
//               a 2-entry skid buffer (output register + skid register).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit RV64_OPS = (XLEN == 64)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [4:0]      out_rd_addr,
    output logic [4:0]      out_rs1_addr,
    output logic [4:0]      out_rs2_addr,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_rd_we,
    output logic            out_illegal
);

    generate
        if ((XLEN != 32) && (XLEN != 64)) begin : g_bad_xlen
            $error("decode_stage: XLEN must be 32 or 64");
        end
    endgenerate

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rd_addr;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            rd_we;
        logic            illegal;
    } dec_t;

    dec_t w_dec;
    dec_t r_out;
    dec_t r_skid;
    logic r_out_valid;
    logic r_skid_valid;
    logic r_in_ready;
    logic w_accept;
    logic w_out_free;

    assign w_dec.pc = in_pc;

    decode_comb #(
        .XLEN     (XLEN),
        .RV64_OPS (RV64_OPS)
    ) u_decode_comb (
        .i_instr    (in_instr),
        .o_opcode   (w_dec.opcode),
        .o_funct3   (w_dec.funct3),
        .o_funct7   (w_dec.funct7),
        .o_rd_addr  (w_dec.rd_addr),
        .o_rs1_addr (w_dec.rs1_addr),
        .o_rs2_addr (w_dec.rs2_addr),
        .o_imm      (w_dec.imm),
        .o_fmt      (w_dec.fmt),
        .o_rd_we    (w_dec.rd_we),
        .o_illegal  (w_dec.illegal)
    );

    assign w_accept   = in_valid && r_in_ready;
    assign w_out_free = !r_out_valid || out_ready;

    // r_in_ready always mirrors !r_skid_valid, kept as its own flop so the
    // upstream handshake sees a clean register output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
            r_out        <= '0;
            r_skid       <= '0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                r_out        <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
                r_in_ready   <= 1'b1;
            end else if (w_accept) begin
                r_out       <= w_dec;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid       <= w_dec;
            r_skid_valid <= 1'b1;
            r_in_ready   <= 1'b0;
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign out_pc       = r_out.pc;
    assign out_opcode   = r_out.opcode;
    assign out_funct3   = r_out.funct3;
    assign out_funct7   = r_out.funct7;
    assign out_rd_addr  = r_out.rd_addr;
    assign out_rs1_addr = r_out.rs1_addr;
    assign out_rs2_addr = r_out.rs2_addr;
    assign out_imm      = r_out.imm;
    assign out_fmt      = r_out.fmt;
    assign out_rd_we    = r_out.rd_we;
    assign out_illegal  = r_out.illegal;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// ============================================================================
// Module      : tb_decode_stage
// Description : Self-checking bench running an RV32 and an RV64 decode stage
//               in lockstep against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_stage;

    localparam int VW = 165;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
    } item_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = '0;
    logic [63:0] pc64 = '0;

    logic        a_in_ready, a_out_valid, a_we, a_ill;
    logic [31:0] a_pc, a_imm;
    logic [6:0]  a_opc, a_f7;
    logic [2:0]  a_f3, a_fmt;
    logic [4:0]  a_rd, a_rs1, a_rs2;

    logic        b_in_ready, b_out_valid, b_we, b_ill;
    logic [63:0] b_pc, b_imm;
    logic [6:0]  b_opc, b_f7;
    logic [2:0]  b_f3, b_fmt;
    logic [4:0]  b_rd, b_rs1, b_rs2;

    int    n_pass = 0;
    int    n_checks = 0;
    item_t q[$];

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr), .in_pc(pc64[31:0]),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_pc),
        .out_opcode(a_opc), .out_funct3(a_f3), .out_funct7(a_f7),
        .out_rd_addr(a_rd), .out_rs1_addr(a_rs1), .out_rs2_addr(a_rs2),
        .out_imm(a_imm), .out_fmt(a_fmt), .out_rd_we(a_we), .out_illegal(a_ill)
    );

    decode_stage #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr), .in_pc(pc64),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_pc),
        .out_opcode(b_opc), .out_funct3(b_f3), .out_funct7(b_f7),
        .out_rd_addr(b_rd), .out_rs1_addr(b_rs1), .out_rs2_addr(b_rs2),
        .out_imm(b_imm), .out_fmt(b_fmt), .out_rd_we(b_we), .out_illegal(b_ill)
    );

    function automatic logic [VW-1:0] obs32();
        return {32'b0, a_pc, a_opc, a_f3, a_f7, a_rd, a_rs1, a_rs2, 32'b0, a_imm, a_fmt, a_we, a_ill};
    endfunction

    function automatic logic [VW-1:0] obs64();
        return {b_pc, b_opc, b_f3, b_f7, b_rd, b_rs1, b_rs2, b_imm, b_fmt, b_we, b_ill};
    endfunction

    // Sign-extend the low n bits of v to 64 bits.
    function automatic logic [63:0] sx(logic [63:0] v, int n);
        return $signed(v << (64 - n)) >>> (64 - n);
    endfunction

    function automatic logic [VW-1:0] exp_vec(logic [31:0] ins, logic [63:0] pc, bit rv64);
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] ii, is, ib, iu, ij, imm, pcx;
        logic [2:0]  fmt;
        bit          we, ill;
        opc = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        ii  = sx({52'b0, ins[31:20]}, 12);
        is  = sx({52'b0, ins[31:25], ins[11:7]}, 12);
        ib  = sx({51'b0, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, 13);
        iu  = sx({32'b0, ins[31:12], 12'b0}, 32);
        ij  = sx({43'b0, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}, 21);
        fmt = 3'd1;
        we  = 1'b0;
        ill = (ins[1:0] != 2'b11);
        case (opc)
            7'h37, 7'h17: begin fmt = 3'd4; we = 1'b1; end
            7'h6F: begin fmt = 3'd5; we = 1'b1; end
            7'h67: begin we = 1'b1; ill |= (f3 != 0); end
            7'h63: begin fmt = 3'd3; ill |= (f3 inside {3'd2, 3'd3}); end
            7'h03: begin
                we = 1'b1;
                ill |= !((f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (rv64 && (f3 inside {3'd3, 3'd6})));
            end
            7'h23: begin fmt = 3'd2; ill |= !((f3 <= 3'd2) || (rv64 && f3 == 3'd3)); end
            7'h13: begin
                we = 1'b1;
                if (f3 == 3'd1) begin
                    if (rv64) ill |= (ins[31:26] != 0);
                    else      ill |= (ins[31:25] != 0);
                end else if (f3 == 3'd5) begin
                    if (rv64) ill |= !(ins[31:26] inside {6'h00, 6'h10});
                    else      ill |= !(f7 inside {7'h00, 7'h20});
                end
            end
            7'h1B: begin we = 1'b1; ill |= !rv64; end
            7'h33: begin
                fmt = 3'd0; we = 1'b1;
                ill |= !((f7 == 7'h00) || ((f7 == 7'h20) && (f3 inside {3'd0, 3'd5})));
            end
            7'h3B: begin fmt = 3'd0; we = 1'b1; ill |= !rv64; end
            7'h0F: fmt = 3'd1;
            7'h73: we = (f3 != 0);
            default: ill = 1'b1;
        endcase
        if (ill) begin
            fmt = 3'd1;
            we  = 1'b0;
        end
        if (ins[11:7] == 0) we = 1'b0;
        case (fmt)
            3'd0:    imm = 64'd0;
            3'd2:    imm = is;
            3'd3:    imm = ib;
            3'd4:    imm = iu;
            3'd5:    imm = ij;
            default: imm = ii;
        endcase
        pcx = pc;
        if (!rv64) begin
            imm = {32'b0, imm[31:0]};
            pcx = {32'b0, pc[31:0]};
        end
        return {pcx, opc, f3, f7, ins[11:7], ins[19:15], ins[24:20], imm, fmt, we, ill};
    endfunction

    function automatic logic [31:0] gen();
        logic [6:0]  opcs[13];
        logic [31:0] x;
        opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
                 7'h13, 7'h1B, 7'h33, 7'h3B, 7'h0F, 7'h73};
        x = $urandom;
        if ($urandom_range(0, 7) != 0) x[6:0] = opcs[$urandom_range(0, 12)];
        if ($urandom_range(0, 1) != 0) x[31:25] = ($urandom_range(0, 1) != 0) ? 7'h00 : 7'h20;
        return x;
    endfunction

    task automatic chk(string tag, logic [VW-1:0] obs, logic [VW-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(logic v, logic [31:0] ins, logic [63:0] pcv, logic rdy, logic fl);
        in_valid  = v;
        in_instr  = ins;
        pc64      = pcv;
        out_ready = rdy;
        flush     = fl;
    endtask

    // Checks handshake and head-of-queue data, advances the model, then one cycle.
    task automatic tick(string tag);
        bit acc, drn;
        chk({tag, "_in_ready32"}, a_in_ready, q.size() < 2);
        chk({tag, "_in_ready64"}, b_in_ready, q.size() < 2);
        chk({tag, "_out_valid32"}, a_out_valid, q.size() > 0);
        chk({tag, "_out_valid64"}, b_out_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk({tag, "_data32"}, obs32(), exp_vec(q[0].instr, q[0].pc, 1'b0));
            chk({tag, "_data64"}, obs64(), exp_vec(q[0].instr, q[0].pc, 1'b1));
        end
        acc = in_valid && (q.size() < 2);
        drn = out_ready && (q.size() > 0);
        if (flush) begin
            q.delete();
        end else begin
            if (drn) q.delete(0);
            if (acc) q.push_back('{in_instr, pc64});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [63:0] rpc();
        return {$urandom, $urandom};
    endfunction

    initial begin
        logic [31:0] ia, ib, ic;
        logic [63:0] pa, pb, pc;

        repeat (2) @(negedge clk);
        chk("rst_out_valid32", a_out_valid, 0);
        chk("rst_in_ready32", a_in_ready, 1);
        chk("rst_data32", obs32(), 0);
        chk("rst_data64", obs64(), 0);
        rst_n = 1'b1;

        drive(1, 32'hFFF00093, rpc(), 1, 0); tick("addi");
        drive(0, 0, rpc(), 1, 0);
        chk("addi_fmt", a_fmt, 1);
        chk("addi_imm", a_imm, 32'hFFFFFFFF);
        chk("addi_rd", a_rd, 1);
        chk("addi_we", a_we, 1);
        chk("addi_ill", a_ill, 0);
        tick("addi_out");

        drive(1, 32'hFE20AE23, rpc(), 1, 0); tick("sw");
        drive(0, 0, rpc(), 1, 0);
        chk("sw_fmt", a_fmt, 2);
        chk("sw_imm", a_imm, 32'hFFFFFFFC);
        chk("sw_rs1", a_rs1, 1);
        chk("sw_rs2", a_rs2, 2);
        chk("sw_we", a_we, 0);
        tick("sw_out");

        drive(1, 32'hFF9FF06F, rpc(), 1, 0); tick("jal");
        drive(0, 0, rpc(), 1, 0);
        chk("jal_fmt", a_fmt, 5);
        chk("jal_imm", a_imm, 32'hFFFFFFF8);
        chk("jal_we", a_we, 0);
        tick("jal_out");

        // Backpressure: two accepted into output+skid, third held off.
        ia = gen(); ib = gen(); ic = gen();
        pa = rpc(); pb = rpc(); pc = rpc();
        drive(1, ia, pa, 0, 0); tick("bp1");
        drive(1, ib, pb, 0, 0); tick("bp2");
        chk("bp_in_ready_low", a_in_ready, 0);
        drive(1, ic, pc, 0, 0); tick("bp3");
        tick("bp_stall");
        drive(1, ic, pc, 1, 0); tick("bp_drain1");
        tick("bp_drain2");
        drive(0, 0, rpc(), 1, 0); tick("bp_drain3");
        tick("bp_idle");

        drive(1, 32'h00000000, rpc(), 1, 0); tick("zero");
        drive(0, 0, rpc(), 1, 0);
        chk("zero_ill", a_ill, 1);
        chk("zero_we", a_we, 0);
        tick("zero_out");
        drive(1, 32'h02000033, rpc(), 1, 0); tick("mul");
        drive(0, 0, rpc(), 1, 0);
        chk("mul_ill", a_ill, 1);
        tick("mul_out");
        drive(1, 32'h0000003B, rpc(), 1, 0); tick("op32");
        drive(0, 0, rpc(), 1, 0);
        chk("op32_ill32", a_ill, 1);
        chk("op32_ill64", b_ill, 0);
        chk("op32_fmt64", b_fmt, 0);
        chk("op32_we64", b_we, 0);
        tick("op32_out");

        // Flush with both registers full and a new instruction presented.
        drive(1, gen(), rpc(), 0, 0); tick("fl1");
        drive(1, gen(), rpc(), 0, 0); tick("fl2");
        drive(1, gen(), rpc(), 0, 1); tick("fl_flush");
        drive(0, 0, rpc(), 1, 0);
        chk("fl_out_valid", a_out_valid, 0);
        chk("fl_in_ready", a_in_ready, 1);
        tick("fl_after");
        drive(1, gen(), rpc(), 1, 0); tick("fl_next");
        drive(0, 0, rpc(), 1, 0); tick("fl_next_out");

        // Asynchronous reset between edges.
        drive(1, gen(), rpc(), 0, 0); tick("ar1");
        drive(1, gen(), rpc(), 0, 0); tick("ar2");
        drive(0, 0, rpc(), 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_out_valid32", a_out_valid, 0);
        chk("ar_in_ready32", a_in_ready, 1);
        chk("ar_out_valid64", b_out_valid, 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 32'hFFF00093, rpc(), 1, 0); tick("ar_first");
        drive(0, 0, rpc(), 1, 0);
        chk("ar_first_valid", a_out_valid, 1);
        tick("ar_first_out");

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, gen(), rpc(), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 39) == 0);
            tick("rnd");
        end
        drive(0, 0, rpc(), 1, 0);
        repeat (3) tick("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
